// File: rtl/section_normalizer_if.sv
// Stream bundle for section_normalizer: upstream sample side (s_*) and
// downstream normalized-result side (m_*).
interface section_normalizer_if;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic [4:0]  s_channel;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [4:0]  m_channel;
    logic        m_overflow;

    modport slave (
        input  s_valid, s_data, s_channel, m_ready,
        output s_ready, m_valid, m_data, m_channel, m_overflow
    );

    modport master (
        output s_valid, s_data, s_channel, m_ready,
        input  s_ready, m_valid, m_data, m_channel, m_overflow
    );
endinterface

// File: rtl/section_normalizer.sv
// Four-stage ADC sample normalizer: (sample - mean) * inv_stdev in Q16.16,
// with saturation, a saturation counter and a global-stall valid/ready pipeline.
module section_normalizer (
    input  logic                   clk,
    input  logic                   rst,
    section_normalizer_if.slave    bus,
    output logic [1:0]             adc_section,
    input  logic [31:0]            mean_in,
    input  logic [31:0]            std_in,
    output logic [15:0]            sat_count
);

    logic               v1, v2, v3, v4;
    logic [15:0]        s1_data, s2_data;
    logic [4:0]         s1_channel, s2_channel, s3_channel;
    logic [31:0]        s2_mean, s2_std, s3_std;
    logic signed [33:0] s3_diff;
    logic [31:0]        m_data_q;
    logic [4:0]         m_channel_q;
    logic               m_overflow_q;

    logic               stall;
    logic               advance;
    logic               accept;
    logic [33:0]        diff;
    logic signed [66:0] product;
    logic signed [66:0] shifted;
    logic               in_range;
    logic [31:0]        result;
    logic               overflow;

    // Only a valid output that is not taken blocks the pipe; bubbles always move.
    assign stall   = v4 & ~bus.m_ready;
    assign advance = ~stall;
    assign accept  = bus.s_valid & advance;

    assign bus.s_ready    = advance;
    assign bus.m_valid    = v4;
    assign bus.m_data     = m_data_q;
    assign bus.m_channel  = m_channel_q;
    assign bus.m_overflow = m_overflow_q;

    // S1 holds during a stall, so the selector keeps returning the same coefficients.
    assign adc_section = s1_channel[4:3];

    always_comb begin
        diff     = {{2{s2_data[15]}}, s2_data, 16'h0000} - {2'b00, s2_mean};
        product  = {{33{s3_diff[33]}}, s3_diff} * {35'd0, s3_std};
        shifted  = product >>> 16;
        in_range = (&shifted[66:31]) | ~(|shifted[66:31]);
        overflow = ~in_range;
        if (in_range) begin
            result = shifted[31:0];
        end else if (shifted[66]) begin
            result = 32'h8000_0000;
        end else begin
            result = 32'h7FFF_FFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            v3           <= 1'b0;
            v4           <= 1'b0;
            s1_data      <= '0;
            s1_channel   <= '0;
            s2_data      <= '0;
            s2_channel   <= '0;
            s2_mean      <= '0;
            s2_std       <= '0;
            s3_diff      <= '0;
            s3_std       <= '0;
            s3_channel   <= '0;
            m_data_q     <= '0;
            m_channel_q  <= '0;
            m_overflow_q <= 1'b0;
            sat_count    <= '0;
        end else begin
            if (advance) begin
                v1 <= accept;
                if (accept) begin
                    s1_data    <= bus.s_data;
                    s1_channel <= bus.s_channel;
                end
                v2           <= v1;
                s2_data      <= s1_data;
                s2_channel   <= s1_channel;
                s2_mean      <= mean_in;
                s2_std       <= std_in;
                v3           <= v2;
                s3_diff      <= diff;
                s3_std       <= s2_std;
                s3_channel   <= s2_channel;
                v4           <= v3;
                m_data_q     <= result;
                m_channel_q  <= s3_channel;
                m_overflow_q <= overflow;
            end
            if (v4 && bus.m_ready && m_overflow_q && (sat_count != '1)) begin
                sat_count <= sat_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_section_normalizer.sv
// Directed-vector bench for section_normalizer with a table-driven
// coefficient selector answering adc_section combinationally.
module tb_section_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  adc_section;
    logic [31:0] mean_in;
    logic [31:0] std_in;
    logic [15:0] sat_count;
    logic [31:0] mean_tab [4];
    logic [31:0] std_tab  [4];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    section_normalizer_if bus ();

    section_normalizer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .adc_section (adc_section),
        .mean_in     (mean_in),
        .std_in      (std_in),
        .sat_count   (sat_count)
    );

    always_comb begin
        mean_in = mean_tab[adc_section];
        std_in  = std_tab[adc_section];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_tab(input int k, input logic [31:0] m, input logic [31:0] s);
        mean_tab[k] = m;
        std_tab[k]  = s;
    endtask

    // One isolated sample through an idle pipeline: checks acceptance,
    // section select, exact 4-cycle latency, result fields and no duplicate.
    task automatic run_single(input logic [15:0] d, input logic [4:0] ch,
                              input logic [31:0] exp_d, input logic exp_ovf,
                              input string name);
        logic [4:0] ch_v;
        ch_v = ch;
        bus.s_data    = d;
        bus.s_channel = ch;
        bus.s_valid   = 1'b1;
        bus.m_ready   = 1'b1;
        #1;
        n_checks++;
        if (bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s s_ready idle: got %b expected 1", name, bus.s_ready);
        end
        step;
        bus.s_valid = 1'b0;
        n_checks++;
        if (adc_section !== ch_v[4:3]) begin
            n_fail++;
            $display("FAIL %s adc_section: got %b expected %b", name, adc_section, ch_v[4:3]);
        end
        step;
        step;
        n_checks++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s early m_valid: got %b expected 0", name, bus.m_valid);
        end
        step;
        n_checks++;
        if (bus.m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s latency m_valid: got %b expected 1", name, bus.m_valid);
        end
        n_checks++;
        if (bus.m_data !== exp_d) begin
            n_fail++;
            $display("FAIL %s m_data: got %h expected %h", name, bus.m_data, exp_d);
        end
        n_checks++;
        if (bus.m_channel !== ch) begin
            n_fail++;
            $display("FAIL %s m_channel: got %0d expected %0d", name, bus.m_channel, ch);
        end
        n_checks++;
        if (bus.m_overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL %s m_overflow: got %b expected %b", name, bus.m_overflow, exp_ovf);
        end
        step;
        n_checks++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s duplicate m_valid: got %b expected 0", name, bus.m_valid);
        end
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_channel = '0;
        bus.m_ready   = 1'b1;
        step;
        step;
        n_checks++;
        if (bus.m_valid !== 1'b0 || sat_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset m_valid/sat_count: got %b/%h expected 0/0000", bus.m_valid, sat_count);
        end
        n_checks++;
        if (bus.m_data !== 32'h0 || bus.m_channel !== 5'd0 || bus.m_overflow !== 1'b0 || adc_section !== 2'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got %h/%0d/%b/%b expected 0/0/0/0",
                     bus.m_data, bus.m_channel, bus.m_overflow, adc_section);
        end
        rst = 1'b0;
        step;
        n_checks++;
        if (bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset s_ready after release: got %b expected 1", bus.s_ready);
        end
    endtask

    task automatic test_basic;
        set_tab(1, 32'h0080_0000, 32'h0002_0000);
        run_single(16'h0100, 5'd9, 32'h0100_0000, 1'b0, "basic");
    endtask

    task automatic test_negative;
        set_tab(0, 32'h0, 32'h0001_0000);
        run_single(16'hFF9C, 5'd0, 32'hFF9C_0000, 1'b0, "negative");
        set_tab(2, 32'h0001_0000, 32'h0001_0000);
        run_single(16'h0000, 5'd17, 32'hFFFF_0000, 1'b0, "mean_sub");
    endtask

    task automatic test_rounding;
        // -1 * 0.5 in Q16.16 must floor to -1 LSB, not truncate to zero
        set_tab(0, 32'h0000_0001, 32'h0000_8000);
        run_single(16'h0000, 5'd0, 32'hFFFF_FFFF, 1'b0, "floor");
    endtask

    task automatic test_boundaries;
        set_tab(3, 32'h0, 32'h0001_0000);
        run_single(16'h8000, 5'd31, 32'h8000_0000, 1'b0, "exact_min");
        run_single(16'h7FFF, 5'd24, 32'h7FFF_0000, 1'b0, "max_in_range");
    endtask

    task automatic test_saturation;
        n_checks++;
        if (sat_count !== 16'd0) begin
            n_fail++;
            $display("FAIL sat_count before: got %h expected 0000", sat_count);
        end
        set_tab(0, 32'h0, 32'h7FFF_FFFF);
        run_single(16'h7FFF, 5'd0, 32'h7FFF_FFFF, 1'b1, "sat_pos");
        n_checks++;
        if (sat_count !== 16'd1) begin
            n_fail++;
            $display("FAIL sat_count 0->1: got %h expected 0001", sat_count);
        end
        set_tab(0, 32'h7FFF_FFFF, 32'h0001_0000);
        run_single(16'h8000, 5'd0, 32'h8000_0000, 1'b1, "sat_neg");
        n_checks++;
        if (sat_count !== 16'd2) begin
            n_fail++;
            $display("FAIL sat_count 1->2: got %h expected 0002", sat_count);
        end
        set_tab(0, 32'h0, 32'h7FFF_FFFF);
        bus.s_data    = 16'h7FFF;
        bus.s_channel = 5'd0;
        bus.m_ready   = 1'b1;
        bus.s_valid   = 1'b1;
        repeat (65533) step;
        bus.s_valid = 1'b0;
        repeat (6) step;
        n_checks++;
        if (sat_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_count reach max: got %h expected ffff", sat_count);
        end
        bus.s_valid = 1'b1;
        repeat (5) step;
        bus.s_valid = 1'b0;
        repeat (6) step;
        n_checks++;
        if (sat_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_count hold max: got %h expected ffff", sat_count);
        end
    endtask

    task automatic test_back_to_back;
        int          sent;
        int          recv;
        int          cyc;
        int          k;
        logic        acc;
        logic        outh;
        logic [31:0] exp_d;
        logic [31:0] hold_d;
        logic [4:0]  hold_c;
        sent   = 0;
        recv   = 0;
        cyc    = 0;
        hold_d = '0;
        hold_c = '0;
        for (int i = 0; i < 4; i++) begin
            set_tab(i, 32'(i) << 16, 32'(i + 1) << 16);
        end
        while (recv < 32 && cyc < 200) begin
            bus.s_valid   = (sent < 32);
            bus.s_data    = 16'(sent);
            bus.s_channel = 5'(sent);
            bus.m_ready   = !(cyc >= 6 && cyc < 9);
            #1;
            if (cyc == 6) begin
                hold_d = bus.m_data;
                hold_c = bus.m_channel;
            end
            if (cyc >= 6 && cyc < 9) begin
                n_checks++;
                if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall s_ready/m_valid cyc %0d: got %b/%b expected 0/1",
                             cyc, bus.s_ready, bus.m_valid);
                end
            end
            if (cyc == 7 || cyc == 8) begin
                n_checks++;
                if (bus.m_data !== hold_d || bus.m_channel !== hold_c) begin
                    n_fail++;
                    $display("FAIL stall stable cyc %0d: got %h/%0d expected %h/%0d",
                             cyc, bus.m_data, bus.m_channel, hold_d, hold_c);
                end
            end
            acc  = bus.s_valid & bus.s_ready;
            outh = bus.m_valid & bus.m_ready;
            if (outh) begin
                k     = recv / 8;
                exp_d = 32'((recv - k) * (k + 1) * 65536);
                n_checks++;
                if (bus.m_data !== exp_d || bus.m_channel !== 5'(recv) || bus.m_overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream out %0d: got %h/%0d/%b expected %h/%0d/0",
                             recv, bus.m_data, bus.m_channel, bus.m_overflow, exp_d, recv);
                end
                recv++;
            end
            step;
            if (acc) sent++;
            cyc++;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        n_checks++;
        if (recv != 32) begin
            n_fail++;
            $display("FAIL stream count: got %0d expected 32", recv);
        end
        step;
        n_checks++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream extra output: got %b expected 0", bus.m_valid);
        end
    endtask

    task automatic test_reset_midstream;
        set_tab(0, 32'h0, 32'h7FFF_FFFF);
        bus.s_data    = 16'h7FFF;
        bus.s_channel = 5'd0;
        bus.m_ready   = 1'b1;
        bus.s_valid   = 1'b1;
        step;
        step;
        bus.s_valid = 1'b0;
        rst         = 1'b1;
        step;
        rst = 1'b0;
        n_checks++;
        if (bus.m_valid !== 1'b0 || sat_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset clear: got %b/%h expected 0/0000", bus.m_valid, sat_count);
        end
        for (int i = 0; i < 6; i++) begin
            step;
            n_checks++;
            if (bus.m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset stale output cycle %0d: got %b expected 0", i, bus.m_valid);
            end
        end
        set_tab(1, 32'h0080_0000, 32'h0002_0000);
        run_single(16'h0100, 5'd9, 32'h0100_0000, 1'b0, "after_reset");
        n_checks++;
        if (sat_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset sat_count: got %h expected 0000", sat_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mean_tab[i] = '0;
            std_tab[i]  = '0;
        end
        test_reset;
        test_basic;
        test_negative;
        test_rounding;
        test_boundaries;
        test_saturation;
        test_back_to_back;
        test_reset_midstream;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
